// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle sequencer and the RV32I datapath.
// master = sequencer (mc_ctrl), slave = datapath / observer side.
interface mc_ctrl_if;
    logic        run;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        ZF;
    logic        PC_Write;
    logic [1:0]  PC_s;
    logic        IR_Write;
    logic        Reg_Write;
    logic        rs2_imm_s;
    logic [1:0]  w_data_s;
    logic        Mem_Write;
    logic [3:0]  ALU_OP;
    logic [3:0]  state;
    logic        retired;
    logic [31:0] inst_cnt;
    logic        illegal;

    modport master (
        input  run, opcode, funct3, funct7_5, ZF,
        output PC_Write, PC_s, IR_Write, Reg_Write, rs2_imm_s, w_data_s,
               Mem_Write, ALU_OP, state, retired, inst_cnt, illegal
    );

    modport slave (
        output run, opcode, funct3, funct7_5, ZF,
        input  PC_Write, PC_s, IR_Write, Reg_Write, rs2_imm_s, w_data_s,
               Mem_Write, ALU_OP, state, retired, inst_cnt, illegal
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I-subset control unit: Moore FSM stepping one instruction
// through fetch, decode, execute, memory and writeback, plus a retired
// instruction counter and a sticky illegal-instruction trap.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | parked at an instruction boundary, waiting for run
// IF     | load IR, PC <= PC+4
// ID     | decode opcode/funct3, pick execute path
// EX_R   | ALU op on rs1,rs2
// EX_I   | ALU op on rs1,imm
// WB_ALU | write ALU result to rd (final)
// EX_LS  | address = rs1+imm
// MEM_RD | synchronous memory read in flight
// WB_LD  | write load data to rd (final)
// MEM_WR | store strobe (final)
// LUI    | write immediate to rd (final)
// JAL    | link rd, PC <= PC0+imm (final)
// EX_JR  | target = rs1+imm
// WB_JR  | link rd, PC <= ALU result (final)
// BR     | compare rs1,rs2; conditional PC <= PC0+imm (final)
// TRAP   | illegal instruction, held until reset
module mc_ctrl (
    input logic      clk,
    input logic      rst,
    mc_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_IF     = 4'd1,
        S_ID     = 4'd2,
        S_EX_R   = 4'd3,
        S_EX_I   = 4'd4,
        S_WB_ALU = 4'd5,
        S_EX_LS  = 4'd6,
        S_MEM_RD = 4'd7,
        S_WB_LD  = 4'd8,
        S_MEM_WR = 4'd9,
        S_LUI    = 4'd10,
        S_JAL    = 4'd11,
        S_EX_JR  = 4'd12,
        S_WB_JR  = 4'd13,
        S_BR     = 4'd14,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    state_t      state_q;
    state_t      state_d;
    logic        is_final;
    logic [31:0] inst_cnt_q;

    assign is_final = (state_q == S_WB_ALU) || (state_q == S_WB_LD) ||
                      (state_q == S_MEM_WR) || (state_q == S_LUI)   ||
                      (state_q == S_JAL)    || (state_q == S_WB_JR) ||
                      (state_q == S_BR);

    // State register; async reset parks the FSM so no strobe survives reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = bus.run ? S_IF : S_IDLE;
            S_IF:     state_d = S_ID;
            S_ID: begin
                case (bus.opcode)
                    OP_R:              state_d = S_EX_R;
                    OP_I:              state_d = S_EX_I;
                    OP_LOAD, OP_STORE: state_d = S_EX_LS;
                    OP_LUI:            state_d = S_LUI;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_EX_JR;
                    OP_BR:             state_d = (bus.funct3 == 3'b000 || bus.funct3 == 3'b001)
                                                 ? S_BR : S_TRAP;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_EX_R:   state_d = S_WB_ALU;
            S_EX_I:   state_d = S_WB_ALU;
            // ID only lets loads and stores into EX_LS, so non-load means store.
            S_EX_LS:  state_d = (bus.opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: state_d = S_WB_LD;
            S_EX_JR:  state_d = S_WB_JR;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = bus.run ? S_IF : S_IDLE;
        endcase
    end

    // Output decode: pure function of state and IR fields (Moore, plus ZF in BR).
    always_comb begin
        bus.PC_Write  = 1'b0;
        bus.PC_s      = 2'b00;
        bus.IR_Write  = 1'b0;
        bus.Reg_Write = 1'b0;
        bus.rs2_imm_s = 1'b0;
        bus.w_data_s  = 2'b00;
        bus.Mem_Write = 1'b0;
        bus.ALU_OP    = 4'b0000;
        case (state_q)
            S_IF: begin
                bus.IR_Write = 1'b1;
                bus.PC_Write = 1'b1;
            end
            S_EX_R: begin
                bus.ALU_OP = {bus.funct7_5, bus.funct3};
            end
            S_EX_I: begin
                // Only SRLI/SRAI use bit 30; for other I-types it is immediate data.
                bus.ALU_OP    = {(bus.funct3 == 3'b101) ? bus.funct7_5 : 1'b0, bus.funct3};
                bus.rs2_imm_s = 1'b1;
            end
            S_WB_ALU: begin
                bus.Reg_Write = 1'b1;
            end
            S_EX_LS, S_EX_JR: begin
                bus.rs2_imm_s = 1'b1;
            end
            S_WB_LD: begin
                bus.Reg_Write = 1'b1;
                bus.w_data_s  = 2'b01;
            end
            S_MEM_WR: begin
                bus.Mem_Write = 1'b1;
            end
            S_LUI: begin
                bus.Reg_Write = 1'b1;
                bus.w_data_s  = 2'b11;
            end
            S_JAL: begin
                bus.Reg_Write = 1'b1;
                bus.w_data_s  = 2'b10;
                bus.PC_Write  = 1'b1;
                bus.PC_s      = 2'b01;
            end
            S_WB_JR: begin
                bus.Reg_Write = 1'b1;
                bus.w_data_s  = 2'b10;
                bus.PC_Write  = 1'b1;
                bus.PC_s      = 2'b10;
            end
            S_BR: begin
                bus.ALU_OP   = 4'b1000;
                bus.PC_s     = 2'b01;
                bus.PC_Write = ((bus.funct3 == 3'b000) &&  bus.ZF) ||
                               ((bus.funct3 == 3'b001) && !bus.ZF);
            end
            default: ;
        endcase
    end

    // Retired-instruction counter, bumped on the edge leaving a final state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_cnt_q <= 32'd0;
        end else if (is_final) begin
            inst_cnt_q <= inst_cnt_q + 32'd1;
        end
    end

    // TRAP only exits through reset, so the state itself is the sticky flag.
    assign bus.state    = state_q;
    assign bus.retired  = is_final;
    assign bus.inst_cnt = inst_cnt_q;
    assign bus.illegal  = (state_q == S_TRAP);

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: expected per-cycle outputs are queued when
// an instruction is issued and compared by a monitor on the falling edge.
module tb_mc_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic [1:0] pcs;
        logic       irw;
        logic       rw;
        logic       rs2;
        logic [1:0] wds;
        logic       mw;
        logic [3:0] alu;
        logic       ret;
    } exp_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_FENCE = 7'b0001111;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   mw_cnt = 0;
    int   br_taken_cnt = 0;
    exp_t sb_q[$];

    mc_ctrl_if bus();
    mc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected outputs for one state, straight from the state/strobe table.
    function automatic exp_t exp_of(input logic [3:0] st, input logic [2:0] f3,
                                    input logic f7, input logic zf);
        exp_t e;
        e = '0;
        e.st = st;
        case (st)
            4'd1:  begin e.pcw = 1'b1; e.irw = 1'b1; end
            4'd3:  e.alu = {f7, f3};
            4'd4:  begin e.alu = {(f3 == 3'b101) ? f7 : 1'b0, f3}; e.rs2 = 1'b1; end
            4'd5:  e.rw = 1'b1;
            4'd6:  e.rs2 = 1'b1;
            4'd8:  begin e.rw = 1'b1; e.wds = 2'b01; end
            4'd9:  e.mw = 1'b1;
            4'd10: begin e.rw = 1'b1; e.wds = 2'b11; end
            4'd11: begin e.rw = 1'b1; e.wds = 2'b10; e.pcw = 1'b1; e.pcs = 2'b01; end
            4'd12: e.rs2 = 1'b1;
            4'd13: begin e.rw = 1'b1; e.wds = 2'b10; e.pcw = 1'b1; e.pcs = 2'b10; end
            4'd14: begin
                e.alu = 4'b1000;
                e.pcs = 2'b01;
                e.pcw = ((f3 == 3'b000) && zf) || ((f3 == 3'b001) && !zf);
            end
            default: ;
        endcase
        e.ret = (st == 4'd5) || (st == 4'd8) || (st == 4'd9) || (st == 4'd10) ||
                (st == 4'd11) || (st == 4'd13) || (st == 4'd14);
        return e;
    endfunction

    // Scoreboard monitor: one expected entry per cycle while the queue is non-empty.
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        got = {bus.state, bus.PC_Write, bus.PC_s, bus.IR_Write, bus.Reg_Write,
               bus.rs2_imm_s, bus.w_data_s, bus.Mem_Write, bus.ALU_OP, bus.retired};
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL sb_cycle t=%0t got=%h (st=%0d) exp=%h (st=%0d)",
                         $time, got, got.st, e, e.st);
            end
        end
        if (bus.Mem_Write === 1'b1) mw_cnt++;
        if (bus.state == 4'd14 && bus.PC_Write === 1'b1) br_taken_cnt++;
    end

    // Issue one instruction. Called at negedge+1 of the cycle before its IF.
    task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic zf, input int drop_at);
        logic [3:0] p[$];
        p = '{4'd1, 4'd2};
        case (op)
            OP_R:     begin p.push_back(4'd3); p.push_back(4'd5); end
            OP_I:     begin p.push_back(4'd4); p.push_back(4'd5); end
            OP_LOAD:  begin p.push_back(4'd6); p.push_back(4'd7); p.push_back(4'd8); end
            OP_STORE: begin p.push_back(4'd6); p.push_back(4'd9); end
            OP_LUI:   p.push_back(4'd10);
            OP_JAL:   p.push_back(4'd11);
            OP_JALR:  begin p.push_back(4'd12); p.push_back(4'd13); end
            OP_BR:    p.push_back((f3 == 3'b000 || f3 == 3'b001) ? 4'd14 : 4'd15);
            default:  p.push_back(4'd15);
        endcase
        foreach (p[i]) sb_q.push_back(exp_of(p[i], f3, f7, zf));
        for (int i = 0; i < p.size(); i++) begin
            @(negedge clk);
            #1;
            if (i == 0) begin
                bus.opcode   = op;
                bus.funct3   = f3;
                bus.funct7_5 = f7;
                bus.ZF       = zf;
            end
            if (i == drop_at) bus.run = 1'b0;
        end
    endtask

    task automatic expect_idle_cnt(input logic [31:0] cnt);
        @(negedge clk);
        #1;
        total++;
        if (bus.state !== 4'd0) begin
            bad++;
            $display("FAIL idle_state got=%0d exp=0", bus.state);
        end
        total++;
        if (bus.inst_cnt !== cnt) begin
            bad++;
            $display("FAIL inst_cnt got=%0d exp=%0d", bus.inst_cnt, cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.run = 1'b0;
        bus.opcode = 7'd0;
        bus.funct3 = 3'd0;
        bus.funct7_5 = 1'b0;
        bus.ZF = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (bus.state !== 4'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", bus.state); end
        total++;
        if (bus.inst_cnt !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", bus.inst_cnt); end
        total++;
        if ({bus.illegal, bus.PC_Write, bus.IR_Write, bus.Reg_Write, bus.Mem_Write, bus.retired} !== 6'b0) begin
            bad++;
            $display("FAIL rst_strobes got=%b exp=000000",
                     {bus.illegal, bus.PC_Write, bus.IR_Write, bus.Reg_Write, bus.Mem_Write, bus.retired});
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (bus.state !== 4'd0) begin bad++; $display("FAIL idle_no_run got=%0d exp=0", bus.state); end
    endtask

    task automatic test_alu_mem_seq();
        int mw0;
        mw0 = mw_cnt;
        bus.run = 1'b1;
        do_instr(OP_R, 3'b000, 1'b0, 1'b0, -1);
        do_instr(OP_I, 3'b000, 1'b0, 1'b0, -1);
        do_instr(OP_LOAD, 3'b010, 1'b0, 1'b0, -1);
        do_instr(OP_STORE, 3'b010, 1'b0, 1'b0, 3);
        expect_idle_cnt(32'd4);
        total++;
        if (mw_cnt - mw0 !== 1) begin bad++; $display("FAIL mem_write_pulses got=%0d exp=1", mw_cnt - mw0); end
    endtask

    task automatic test_branch();
        int br0;
        br0 = br_taken_cnt;
        bus.run = 1'b1;
        do_instr(OP_BR, 3'b000, 1'b0, 1'b1, -1);
        do_instr(OP_BR, 3'b000, 1'b0, 1'b0, -1);
        do_instr(OP_BR, 3'b001, 1'b0, 1'b0, 2);
        expect_idle_cnt(32'd7);
        total++;
        if (br_taken_cnt - br0 !== 2) begin bad++; $display("FAIL br_taken got=%0d exp=2", br_taken_cnt - br0); end
    endtask

    task automatic test_jump();
        bus.run = 1'b1;
        do_instr(OP_JAL, 3'b000, 1'b0, 1'b0, -1);
        do_instr(OP_JALR, 3'b000, 1'b0, 1'b0, 3);
        expect_idle_cnt(32'd9);
    endtask

    task automatic test_back_to_back();
        bus.run = 1'b1;
        do_instr(OP_R, 3'b000, 1'b1, 1'b0, -1);
        do_instr(OP_I, 3'b101, 1'b1, 1'b0, -1);
        do_instr(OP_I, 3'b100, 1'b1, 1'b0, -1);
        do_instr(OP_LUI, 3'b011, 1'b1, 1'b0, 2);
        expect_idle_cnt(32'd13);
    endtask

    task automatic test_reset_mid();
        bus.run = 1'b1;
        sb_q.push_back(exp_of(4'd1, 3'b000, 1'b0, 1'b0));
        sb_q.push_back(exp_of(4'd2, 3'b000, 1'b0, 1'b0));
        sb_q.push_back(exp_of(4'd3, 3'b000, 1'b0, 1'b0));
        @(negedge clk);
        #1;
        bus.opcode = OP_R;
        bus.funct3 = 3'b000;
        bus.funct7_5 = 1'b0;
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        rst = 1'b1;
        bus.run = 1'b0;
        #1;
        total++;
        if (bus.state !== 4'd0) begin bad++; $display("FAIL mid_rst_state got=%0d exp=0", bus.state); end
        total++;
        if (bus.Reg_Write !== 1'b0) begin bad++; $display("FAIL mid_rst_regwrite got=%b exp=0", bus.Reg_Write); end
        total++;
        if (bus.inst_cnt !== 32'd0) begin bad++; $display("FAIL mid_rst_cnt got=%0d exp=0", bus.inst_cnt); end
        @(posedge clk);
        #1;
        total++;
        if ({bus.Reg_Write, bus.state} !== 5'd0) begin
            bad++;
            $display("FAIL mid_rst_hold got=%b exp=00000", {bus.Reg_Write, bus.state});
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        expect_idle_cnt(32'd0);
    endtask

    task automatic test_trap();
        bus.run = 1'b1;
        do_instr(OP_R, 3'b111, 1'b0, 1'b0, -1);
        do_instr(OP_FENCE, 3'b000, 1'b0, 1'b0, -1);
        for (int i = 0; i < 6; i++) begin
            bus.run = i[0];
            @(negedge clk);
            #1;
            total++;
            if ({bus.state, bus.illegal, bus.retired} !== {4'd15, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL trap_hold cyc=%0d got st=%0d ill=%b ret=%b exp st=15 ill=1 ret=0",
                         i, bus.state, bus.illegal, bus.retired);
            end
        end
        total++;
        if (bus.inst_cnt !== 32'd1) begin bad++; $display("FAIL trap_cnt got=%0d exp=1", bus.inst_cnt); end
        rst = 1'b1;
        bus.run = 1'b0;
        #1;
        total++;
        if (bus.illegal !== 1'b0) begin bad++; $display("FAIL trap_clear got=%b exp=0", bus.illegal); end
        @(negedge clk);
        #1;
        rst = 1'b0;
        bus.run = 1'b1;
        do_instr(OP_BR, 3'b010, 1'b0, 1'b0, -1);
        bus.run = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if ({bus.state, bus.illegal} !== {4'd15, 1'b1}) begin
            bad++;
            $display("FAIL br_f3_trap got st=%0d ill=%b exp st=15 ill=1", bus.state, bus.illegal);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        expect_idle_cnt(32'd0);
    endtask

    task automatic test_run_drop_wrap();
        force dut.inst_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        #1;
        release dut.inst_cnt_q;
        expect_idle_cnt(32'hFFFF_FFFF);
        bus.run = 1'b1;
        do_instr(OP_LOAD, 3'b010, 1'b0, 1'b0, 2);
        expect_idle_cnt(32'd0);
        expect_idle_cnt(32'd0);
        bus.run = 1'b1;
        do_instr(OP_I, 3'b001, 1'b1, 1'b0, 3);
        expect_idle_cnt(32'd1);
    endtask

    initial begin
        test_reset();
        test_alu_mem_seq();
        test_branch();
        test_jump();
        test_back_to_back();
        test_reset_mid();
        test_trap();
        test_run_drop_wrap();
        total++;
        if (sb_q.size() !== 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
